// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing sets, sync polarity constants and a line/frame total helper.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned display;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } axis_timing_t;

    localparam axis_timing_t VGA640_H = '{display: 640, front: 16, sync: 96,  back: 48};
    localparam axis_timing_t VGA640_V = '{display: 480, front: 10, sync: 2,   back: 33};
    localparam axis_timing_t VGA800_H = '{display: 800, front: 40, sync: 128, back: 88};
    localparam axis_timing_t VGA800_V = '{display: 600, front: 1,  sync: 4,   back: 23};

    localparam logic SYNC_ACT_LOW  = 1'b0;
    localparam logic SYNC_ACT_HIGH = 1'b1;

    function automatic int unsigned axis_total(input int unsigned display, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
        return display + front + sync + back;
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel tick divider: p_tick is high one clk in every CLK_DIV while en is high (CLK_DIV=1 => always).
// Tick is combinational from the count register; en low clears the count on the next edge, no backpressure.
module pixel_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic p_tick
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (!en || div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign p_tick = en && (div_q == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel tick, H/V counters, registered syncs (1 clk behind counters), strobes.
// Free-running with no backpressure; en low parks at (0,0). VGA_TIMING_FRAME_CNT_EN adds frame_cnt.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_DISPLAY = VGA640_H.display,
    parameter int unsigned H_FRONT   = VGA640_H.front,
    parameter int unsigned H_SYNC    = VGA640_H.sync,
    parameter int unsigned H_BACK    = VGA640_H.back,
    parameter int unsigned V_DISPLAY = VGA640_V.display,
    parameter int unsigned V_FRONT   = VGA640_V.front,
    parameter int unsigned V_SYNC    = VGA640_V.sync,
    parameter int unsigned V_BACK    = VGA640_V.back,
    parameter logic        HSYNC_POL = SYNC_ACT_LOW,
    parameter logic        VSYNC_POL = SYNC_ACT_LOW,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned FRAME_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    output logic             p_tick,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic             line_end,
    output logic             frame_end
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [FRAME_W-1:0] frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYN_S = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYN_E = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_SYN_S = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYN_E = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    if (H_TOTAL > (64'd1 << CNT_W) || V_TOTAL > (64'd1 << CNT_W)) begin : g_cnt_w_chk
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end
    if (CLK_DIV < 1 || FRAME_W < 1) begin : g_param_chk
        $error("vga_timing_gen: CLK_DIV and FRAME_W must be >= 1");
    end

    // Gating with reset_n keeps tick, strobes and video_on low while reset is held.
    logic run;
    assign run = en && reset_n;

    pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (run),
        .p_tick  (p_tick)
    );

    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!run) begin
            x_d = '0;
            y_d = '0;
        end else if (p_tick) begin
            x_d = (x_q == H_LAST) ? '0 : x_q + CNT_W'(1);
            if (x_q == H_LAST) begin
                y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        hsync_d = (run && x_q >= H_SYN_S && x_q <= H_SYN_E) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = (run && y_q >= V_SYN_S && y_q <= V_SYN_E) ? VSYNC_POL : ~VSYNC_POL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = run && (x_q < H_VIS) && (y_q < V_VIS);
    assign line_end  = p_tick && (x_q == H_LAST);
    assign frame_end = line_end && (y_q == V_LAST);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Counts completed frames; survives en low, cleared only by reset.
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_end ? frame_cnt_q + FRAME_W'(1) : frame_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
